uart_word_rx: RTL and testbench
===============================

// Module: uart_word_rx
// PURPOSE
//  UART receiver, the PC->FPGA counterpart of the Do_transmition TX path.
//  Deserialises 8N1 bytes on rxd and packs WORD_BYTES bytes (MSB byte first) into one word.
//  The word is used as a host command/config word (channel select, FFT bin index, display mode).
//  Sits beside the TX path; consumers see a one-cycle word_valid strobe.
// PARAMETERS
//  CLK_HZ        100_000_000  system clock frequency
//  BAUD          9600         line rate; CLKS_PER_BIT = CLK_HZ/BAUD (10416 at defaults), integer-truncated
//  WORD_BYTES    2            bytes per word, range 1..4; word width = 8*WORD_BYTES
//  TIMEOUT_BITS  20           idle bit-times after a byte before a partial word is discarded
// PORTS
//  clk         in   1              system clock, rising edge
//  rst_n       in   1              asynchronous active-low reset
//  rxd         in   1              serial input, idle high, asynchronous to clk
//  byte_out    out  8              last good byte
//  byte_valid  out  1              1-cycle strobe: byte_out updated
//  word_out    out  8*WORD_BYTES   last complete word
//  word_valid  out  1              1-cycle strobe: word_out updated
//  frame_err   out  1              1-cycle strobe: stop bit sampled low
//  busy        out  1              high from start-bit detect until the cycle after stop-bit sampling
// BEHAVIOUR
//  Reset: every output is 0; FSM = IDLE; byte/word assemblers and counters are cleared.
//    Reset is honoured mid-frame; the partial byte and word are dropped.
//  rxd passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value (rx_s).
//  FSM (byte level):
//   IDLE : on rx_s==0 -> START; load bit counter with CLKS_PER_BIT/2.
//   START: at count expiry, if rx_s==0 -> DATA, else -> IDLE (glitch rejected, no strobe).
//   DATA : sample rx_s every CLKS_PER_BIT, LSB first, 8 samples -> STOP.
//   STOP : sample one CLKS_PER_BIT later.
//          If 1: byte_out <= shifted byte and byte_valid = 1 for the next cycle.
//          If 0: frame_err = 1 for one cycle, byte discarded, word assembler cleared.
//          Either way -> IDLE.
//   A break (line held low) gives exactly one frame_err; no new start is accepted until rx_s returns high.
//  Latency: byte_valid rises 1 clk after the mid-stop-bit sample, i.e. ~9.5 bit-times after the start edge.
//  Word assembly:
//   - Each good byte is shifted into word_sr (new byte enters the LSB, earlier bytes move up); byte_cnt++.
//   - When byte_cnt reaches WORD_BYTES:
//       * word_out is loaded in the same cycle as byte_valid;
//       * word_valid pulses in that cycle;
//       * byte_cnt wraps to 0.
//   - WORD_BYTES==1: word_valid coincides with every byte_valid.
//  Timeout:
//   - While 0<byte_cnt<WORD_BYTES and FSM idle, a timer counts clocks.
//   - At TIMEOUT_BITS*CLKS_PER_BIT the partial word is silently cleared (no strobe).
//   - The timer resets on every start-bit detect.
//  Simultaneous events: a frame error and a timeout cannot coincide; a frame error always wins over word completion.
//  No backpressure: a consumer must capture word_out on word_valid; word_out holds until the next word.
// STRUCTURE
//  Shared package uart_pkg:
//   - localparam function clks_per_bit(CLK_HZ,BAUD);
//   - FSM state encoding IDLE/START/DATA/STOP (2-bit);
//   - UART_DATA_BITS=8.
//  The Do_transmition rework shares the same package.
//  One sub-module, uart_byte_rx: synchroniser + bit FSM -> byte_out/byte_valid/frame_err/busy.
//  The word packer and timeout timer stay in uart_word_rx.
// TESTING (BAUD=9600 clocked at 100 MHz; bench also runs CLK_HZ=1_600_000 for speed)
//  1. Reset, then byte 0xA5 with a good stop bit -> one byte_valid, byte_out=0xA5, no word_valid, frame_err=0.
//  2. Bytes 0x12 then 0x34 back-to-back -> word_valid once, word_out=0x1234, exactly 2 byte_valid strobes.
//  3. 300 ns low glitch on idle rxd -> no strobes, busy drops back to 0 by mid-start-bit.
//  4. Byte 0x55 with stop bit=0, then 0xAB, 0xCD -> one frame_err, no byte_valid for 0x55, word_out=0xABCD.
//  5. Byte 0x77, idle 25 bit-times, then 0x88, 0x99 -> the 0x77 partial is discarded, word_out=0x8899.
//  6. rst_n low during bit 4 of 0xF0, release, send 0x01, 0x02 -> outputs 0 during reset; word_out=0x0102, no frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing helper, byte-level FSM encoding, frame width.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   // Byte-level receive/transmit FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   // Clocks per bit period, integer-truncated
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: rxd synchroniser plus start/data/stop bit FSM.
// Emits the received byte with a one-cycle byte_valid, or a one-cycle frame_err
// when the stop bit is low. After a frame error no new start is accepted until
// the line has been seen high again, so a held break yields a single error.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy,
   output logic       start_det,
   output logic       byte_ok,
   output logic [7:0] byte_data,
   output logic [1:0] state_dbg
);

   localparam int CW   = $clog2(CLKS_PER_BIT + 1);
   localparam int HALF = CLKS_PER_BIT / 2;

   logic          rx_meta;
   logic          rx_s;
   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          wait_high;
   logic          tick;

   // Two-flop synchroniser, idles high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
      end
   end

   // Sample-point and event decode; the counter expires when it reaches zero
   always_comb begin
      tick      = (cnt == '0);
      start_det = (state == ST_IDLE) && !rx_s && !wait_high;
      byte_ok   = (state == ST_STOP) && tick && rx_s;
      byte_data = shreg;
      busy      = (state != ST_IDLE);
      state_dbg = state;
   end

   // Bit FSM: half-bit to mid-start, then one full bit per data/stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         wait_high  <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_s) wait_high <= 1'b0;
               if (start_det) begin
                  state <= ST_START;
                  cnt   <= CW'(HALF - 1);
               end
            end
            ST_START: begin
               if (tick) begin
                  if (!rx_s) begin
                     state   <= ST_DATA;
                     cnt     <= CW'(CLKS_PER_BIT - 1);
                     bit_idx <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shreg <= {rx_s, shreg[7:1]};
                  cnt   <= CW'(CLKS_PER_BIT - 1);
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) state <= ST_STOP;
                  else bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               if (tick) begin
                  state <= ST_IDLE;
                  if (rx_s) begin
                     byte_out   <= shreg;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     wait_high <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: packs WORD_BYTES good bytes, first byte most significant,
// into word_out with a one-cycle word_valid aligned to the last byte_valid.
// A frame error or an idle gap of TIMEOUT_BITS bit-times drops a partial word.
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int BAUD         = 9600,
   parameter int WORD_BYTES   = 2,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rxd,
   output logic [7:0]              byte_out,
   output logic                    byte_valid,
   output logic [8*WORD_BYTES-1:0] word_out,
   output logic                    word_valid,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int CPB      = clks_per_bit(CLK_HZ, BAUD);
   localparam int W        = UART_DATA_BITS * WORD_BYTES;
   localparam int TO_LIMIT = TIMEOUT_BITS * CPB;
   localparam int TW       = $clog2(TO_LIMIT + 1);

   logic          start_det;
   logic          byte_ok;
   logic [7:0]    byte_data;
   logic [1:0]    rx_state;
   logic [W-1:0]  word_sr;
   logic [W-1:0]  next_word;
   logic [2:0]    byte_cnt;
   logic          word_last;
   logic [TW-1:0] timer;
   logic          timer_run;
   logic          timeout_hit;

   uart_byte_rx #(.CLKS_PER_BIT(CPB)) u_byte_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .busy       (busy),
      .start_det  (start_det),
      .byte_ok    (byte_ok),
      .byte_data  (byte_data),
      .state_dbg  (rx_state)
   );

   // New byte enters the LSB; timer runs only while idle holding a partial word
   always_comb begin
      next_word   = (word_sr << 8) | W'(byte_data);
      word_last   = (byte_cnt == 3'(WORD_BYTES - 1));
      timer_run   = (rx_state == ST_IDLE) && !start_det && (byte_cnt != '0);
      timeout_hit = timer_run && (timer == TW'(TO_LIMIT - 1));
   end

   // Inter-byte idle timer, restarted by every start-bit detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          timer <= '0;
      else if (!timer_run) timer <= '0;
      else                 timer <= timer + 1'b1;
   end

   // Word packer: updates on the stop-bit sample so word_valid lines up with byte_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_sr    <= '0;
         byte_cnt   <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (frame_err || timeout_hit) begin
            word_sr  <= '0;
            byte_cnt <= '0;
         end else if (byte_ok) begin
            if (word_last) begin
               word_out   <= next_word;
               word_valid <= 1'b1;
               word_sr    <= '0;
               byte_cnt   <= '0;
            end else begin
               word_sr  <= next_word;
               byte_cnt <= byte_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed scenarios plus random byte streams.
// Stimulus pushes expectations from a byte/word list model; a negedge monitor
// pops and compares whenever a strobe appears.
module tb_uart_word_rx;

   localparam int CLK_HZ       = 1_600_000;
   localparam int BAUD         = 9600;
   localparam int WORD_BYTES   = 2;
   localparam int TIMEOUT_BITS = 20;
   localparam int CPB          = CLK_HZ / BAUD;
   localparam int W            = 8 * WORD_BYTES;

   logic         clk;
   logic         rst_n;
   logic         rxd;
   logic [7:0]   byte_out;
   logic         byte_valid;
   logic [W-1:0] word_out;
   logic         word_valid;
   logic         frame_err;
   logic         busy;

   int tests = 0;
   int fails = 0;

   logic [7:0]   exp_byte_q[$];
   logic [W-1:0] exp_word_q[$];
   int           exp_ferr_n = 0;
   logic [7:0]   partial[$];

   uart_word_rx #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .WORD_BYTES   (WORD_BYTES),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rxd        (rxd),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .word_out   (word_out),
      .word_valid (word_valid),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: list of received bytes, words formed first-byte-high
   task automatic model_good(input logic [7:0] b);
      logic [W-1:0] w;
      exp_byte_q.push_back(b);
      partial.push_back(b);
      if (partial.size() == WORD_BYTES) begin
         w = '0;
         foreach (partial[i]) w = (w << 8) | W'(partial[i]);
         exp_word_q.push_back(w);
         partial.delete();
      end
   endtask

   task automatic model_bad();
      exp_ferr_n++;
      partial.delete();
   endtask

   // Drivers
   task automatic idle_bits(input int n);
      rxd = 1'b1;
      repeat (n * CPB) @(posedge clk);
      if (n >= TIMEOUT_BITS + 3) partial.delete();
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(posedge clk);
      end
      rxd = stop_ok;
      repeat (CPB) @(posedge clk);
      rxd = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b, input int gap);
      model_good(b);
      send_frame(b, 1'b1);
      idle_bits(gap);
   endtask

   task automatic send_bad(input logic [7:0] b, input int gap);
      model_bad();
      send_frame(b, 1'b0);
      idle_bits(gap);
   endtask

   task automatic check_all_zero(input string tag);
      @(negedge clk);
      check({tag, "_byte_out"}, byte_out, 0);
      check({tag, "_word_out"}, word_out, 0);
      check({tag, "_strobes"}, {byte_valid, word_valid, frame_err}, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n) begin
         if (byte_valid) begin
            if (exp_byte_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL byte_unexpected: got byte %h, expected none", byte_out);
            end else begin
               check("byte_out", byte_out, exp_byte_q.pop_front());
            end
         end
         if (word_valid) begin
            check("word_with_byte", byte_valid, 1);
            if (exp_word_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL word_unexpected: got word %h, expected none", word_out);
            end else begin
               check("word_out", word_out, exp_word_q.pop_front());
            end
         end
         if (frame_err) begin
            tests++;
            if (exp_ferr_n == 0) begin
               fails++;
               $display("FAIL frame_err_unexpected: got 1 expected 0");
            end else begin
               exp_ferr_n--;
            end
         end
      end
   end

   // Main sequence
   initial begin
      logic [7:0] b;
      bit         bad;
      int         gap;

      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (5) @(posedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      idle_bits(2);

      // Single byte, then let its partial word time out
      send_good(8'hA5, 25);

      // Two bytes form one word
      send_good(8'h12, 1);
      send_good(8'h34, 2);

      // Short low glitch: busy rises then falls at mid-start, no strobes
      rxd = 1'b0;
      repeat (30) @(posedge clk);
      rxd = 1'b1;
      @(negedge clk);
      check("glitch_busy_high", busy, 1);
      repeat (CPB / 2 + 10) @(posedge clk);
      @(negedge clk);
      check("glitch_busy_low", busy, 0);
      idle_bits(2);

      // Bad stop bit, then a clean word
      send_bad(8'h55, 1);
      send_good(8'hAB, 1);
      send_good(8'hCD, 2);

      // Partial word discarded by idle timeout
      send_good(8'h77, 25);
      send_good(8'h88, 1);
      send_good(8'h99, 2);
      check("word_hold", word_out, 16'h8899);

      // Break: held low gives exactly one frame error and no restart
      model_bad();
      rxd = 1'b0;
      repeat (20 * CPB) @(posedge clk);
      @(negedge clk);
      check("break_busy", busy, 0);
      repeat (10 * CPB) @(posedge clk);
      idle_bits(3);

      // Random byte stream with occasional bad stops and long gaps
      for (int k = 0; k < 10; k++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 5) == 0);
         gap = ($urandom_range(0, 5) == 0) ? $urandom_range(25, 27) : $urandom_range(1, 3);
         if (bad) send_bad(b, gap);
         else     send_good(b, gap);
      end
      idle_bits(25);

      // Reset during bit 4 of 0xF0, then a clean word
      b = 8'hF0;
      rxd = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         rxd = b[i];
         repeat (CPB) @(posedge clk);
      end
      rxd = b[4];
      repeat (CPB / 2) @(posedge clk);
      rst_n = 1'b0;
      partial.delete();
      repeat (3) @(posedge clk);
      check_all_zero("midreset");
      rxd = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      idle_bits(3);
      send_good(8'h01, 1);
      send_good(8'h02, 3);

      // Every expected strobe must have been seen
      check("bytes_left", exp_byte_q.size(), 0);
      check("words_left", exp_word_q.size(), 0);
      check("ferr_left", exp_ferr_n, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
